// File: rtl/tcase_pkg.sv
// Shared definitions for the case-decoder sweep block.
//   CodeW   : default width of ctrl codes and decoder output
//   SumExtW : extra sum bits above the code width, so 2^W steps never overflow
//   SumW    : default running-sum width (CodeW + SumExtW)
//   LatW    : width of the hold counter (covers latencies 0..15)
//   state_e : sweep FSM states
package tcase_pkg;

  localparam int unsigned CodeW   = 4;
  localparam int unsigned SumExtW = 4;
  localparam int unsigned SumW    = CodeW + SumExtW;
  localparam int unsigned LatW    = 4;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StDone
  } state_e;

endpackage

// File: rtl/tcase_hold_cnt.sv
// Load-and-countdown hold counter.
//   clk      : clock
//   rst      : synchronous active-high reset, clears the count
//   load     : load load_val (wins over counting)
//   load_val : value to load
//   en       : count down by one while non-zero
//   tc       : terminal count, high while the count is zero
module tcase_hold_cnt
  import tcase_pkg::*;
#(
  parameter int unsigned Width = LatW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/tcase_sweep.sv
// Sweeps ctrl codes from first_code to last_code (ascending, modulo 2^W) into an
// attached case decoder, holding each code LAT+1 cycles and capturing the decoder
// output on the last edge of each hold.
//   clk, rst              : clock, synchronous active-high reset
//   start                 : one-cycle sweep request, only honoured in IDLE
//   first_code, last_code : sweep bounds, latched on an accepted start
//   ctrl                  : code driven to the decoder
//   dec_out               : decoder output returned to this block
//   busy                  : sweep in progress
//   smp_valid             : one-cycle pulse per captured step
//   smp_code, smp_data    : code and captured decoder output of the last sample
//   sum                   : running zero-extended sum of captured dec_out values
//   done                  : one-cycle pulse, one cycle after the final sample
module tcase_sweep
  import tcase_pkg::*;
#(
  parameter int unsigned LAT = 1,
  parameter int unsigned W   = CodeW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [W-1:0]         first_code,
  input  logic [W-1:0]         last_code,
  output logic [W-1:0]         ctrl,
  input  logic [W-1:0]         dec_out,
  output logic                 busy,
  output logic                 smp_valid,
  output logic [W-1:0]         smp_code,
  output logic [W-1:0]         smp_data,
  output logic [W+SumExtW-1:0] sum,
  output logic                 done
);

  localparam int unsigned      SW      = W + SumExtW;
  localparam logic [LatW-1:0]  LatLoad = LatW'(LAT);

  state_e state_d, state_q;

  logic [W-1:0]  ctrl_d, ctrl_q;
  logic [W-1:0]  last_d, last_q;
  logic [W-1:0]  smp_code_d, smp_code_q;
  logic [W-1:0]  smp_data_d, smp_data_q;
  logic [SW-1:0] sum_d, sum_q;
  logic          smp_valid_d, smp_valid_q;
  // Set once the final code is captured; the FSM leaves HOLD one cycle later so
  // done never coincides with the last smp_valid.
  logic          fin_d, fin_q;

  logic accept;
  logic capture;
  logic is_final;
  logic hold_tc;
  logic cnt_load;

  assign accept   = (state_q == StIdle) && start;
  assign capture  = (state_q == StHold) && !fin_q && hold_tc;
  assign is_final = (ctrl_q == last_q);
  assign cnt_load = accept || (capture && !is_final);

  tcase_hold_cnt #(
    .Width (LatW)
  ) u_hold_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LatLoad),
    .en       (state_q == StHold),
    .tc       (hold_tc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StHold;
      StHold: if (fin_q) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StHold:  busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    ctrl_d      = ctrl_q;
    last_d      = last_q;
    smp_code_d  = smp_code_q;
    smp_data_d  = smp_data_q;
    sum_d       = sum_q;
    fin_d       = fin_q;
    smp_valid_d = 1'b0;
    if (accept) begin
      ctrl_d = first_code;
      last_d = last_code;
      sum_d  = '0;
      fin_d  = 1'b0;
    end
    if (capture) begin
      smp_valid_d = 1'b1;
      smp_code_d  = ctrl_q;
      smp_data_d  = dec_out;
      sum_d       = sum_q + SW'(dec_out);
      if (is_final) begin
        fin_d = 1'b1;
      end else begin
        ctrl_d = ctrl_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q      <= '0;
      last_q      <= '0;
      smp_code_q  <= '0;
      smp_data_q  <= '0;
      sum_q       <= '0;
      fin_q       <= 1'b0;
      smp_valid_q <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      last_q      <= last_d;
      smp_code_q  <= smp_code_d;
      smp_data_q  <= smp_data_d;
      sum_q       <= sum_d;
      fin_q       <= fin_d;
      smp_valid_q <= smp_valid_d;
    end
  end

  assign ctrl      = ctrl_q;
  assign smp_valid = smp_valid_q;
  assign smp_code  = smp_code_q;
  assign smp_data  = smp_data_q;
  assign sum       = sum_q;

endmodule

// File: tb/tb_tcase_sweep.sv
// Bench for tcase_sweep: one instance with LAT=1 and a registered identity decoder,
// one with LAT=0 and a combinational identity decoder.
module tb_tcase_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1, start0;
  logic [3:0] first_code, last_code;

  logic [3:0] ctrl1, dec1, sc1, sd1;
  logic       busy1, sv1, done1;
  logic [7:0] sum1;
  logic [3:0] ctrl0, dec0, sc0, sd0;
  logic       busy0, sv0, done0;
  logic [7:0] sum0;

  tcase_sweep #(.LAT(1), .W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .first_code(first_code), .last_code(last_code),
    .ctrl(ctrl1), .dec_out(dec1), .busy(busy1), .smp_valid(sv1), .smp_code(sc1),
    .smp_data(sd1), .sum(sum1), .done(done1)
  );

  tcase_sweep #(.LAT(0), .W(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .first_code(first_code), .last_code(last_code),
    .ctrl(ctrl0), .dec_out(dec0), .busy(busy0), .smp_valid(sv0), .smp_code(sc0),
    .smp_data(sd0), .sum(sum0), .done(done0)
  );

  // Decoder stubs
  always @(posedge clk) dec1 <= ctrl1;
  assign dec0 = ctrl0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor follows whichever instance is under test
  bit         mon_sel = 1'b1;
  logic [3:0] m_ctrl, m_sc, m_sd;
  logic       m_busy, m_sv, m_done;
  logic [7:0] m_sum;
  assign m_ctrl = mon_sel ? ctrl1 : ctrl0;
  assign m_sc   = mon_sel ? sc1   : sc0;
  assign m_sd   = mon_sel ? sd1   : sd0;
  assign m_busy = mon_sel ? busy1 : busy0;
  assign m_sv   = mon_sel ? sv1   : sv0;
  assign m_done = mon_sel ? done1 : done0;
  assign m_sum  = mon_sel ? sum1  : sum0;

  int   q_code[$];
  int   q_data[$];
  int   q_cyc[$];
  int   done_cnt  = 0;
  int   done_cyc  = 0;
  int   overlap   = 0;
  logic [3:0] done_ctrl;
  logic       done_busy;

  always @(negedge clk) begin
    if (m_sv === 1'b1) begin
      q_code.push_back(int'(m_sc));
      q_data.push_back(int'(m_sd));
      q_cyc.push_back(cyc);
    end
    if (m_done === 1'b1) begin
      done_cnt++;
      done_cyc  = cyc;
      done_ctrl = m_ctrl;
      done_busy = m_busy;
    end
    if (m_sv === 1'b1 && m_done === 1'b1) overlap++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: codes visited, their count and their sum, from the sweep rules.
  task automatic model(input logic [3:0] f, input logic [3:0] l,
                       output int codes[$], output int n, output int s);
    int c;
    codes = {};
    n = ((int'(l) - int'(f) + 16) % 16) + 1;
    s = 0;
    c = int'(f);
    for (int i = 0; i < n; i++) begin
      codes.push_back(c);
      s += c;
      c = (c + 1) % 16;
    end
  endtask

  task automatic run_sweep(input bit sel, input logic [3:0] f, input logic [3:0] l,
                           input bit spam, input int tbl_n, input int tbl_s, input string tag);
    int codes[$];
    int n, s, lat, base, dbase, ov0, s0, waited, got, lim;
    model(f, l, codes, n, s);
    lat     = sel ? 1 : 0;
    mon_sel = sel;
    base    = q_code.size();
    dbase   = done_cnt;
    ov0     = overlap;
    first_code = f;
    last_code  = l;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    s0 = cyc + 1;
    @(negedge clk); #1;
    check({tag, " busy_after_start"}, m_busy, 1);
    check({tag, " ctrl_first"}, m_ctrl, f);
    if (!spam) begin
      start1 = 1'b0;
      start0 = 1'b0;
    end
    waited = 0;
    while (done_cnt == dbase && waited < 400) begin
      if (spam) begin
        first_code = 4'($urandom);
        last_code  = 4'($urandom);
      end
      @(negedge clk); #1;
      waited++;
    end
    start1 = 1'b0;
    start0 = 1'b0;
    check({tag, " done_seen"}, done_cnt - dbase, 1);
    got = q_code.size() - base;
    check({tag, " n_samples"}, got, n);
    if (tbl_n >= 0) check({tag, " n_table"}, got, tbl_n);
    lim = (got < n) ? got : n;
    for (int i = 0; i < lim; i++) begin
      check({tag, " smp_code"}, q_code[base+i], codes[i]);
      check({tag, " smp_data"}, q_data[base+i], codes[i]);
      check({tag, " smp_time"}, q_cyc[base+i] - s0, (i + 1) * (lat + 1));
    end
    check({tag, " sum"}, m_sum, s);
    if (tbl_s >= 0) check({tag, " sum_table"}, m_sum, tbl_s);
    if (got > 0) check({tag, " done_delay"}, done_cyc - q_cyc[q_code.size()-1], 1);
    check({tag, " done_ctrl"}, done_ctrl, l);
    check({tag, " done_busy"}, done_busy, 0);
    repeat (3) @(negedge clk);
    #1;
    check({tag, " single_done"}, done_cnt - dbase, 1);
    check({tag, " no_overlap"}, overlap - ov0, 0);
    check({tag, " sum_hold"}, m_sum, s);
    check({tag, " ctrl_hold"}, m_ctrl, l);
  endtask

  typedef struct {
    logic [3:0] f;
    logic [3:0] l;
    bit         sel;
    int         n;
    int         s;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base, dbase, waited;
    tbl[0] = '{f: 4'd0,  l: 4'd9,  sel: 1'b1, n: 10, s: 45};
    tbl[1] = '{f: 4'd14, l: 4'd1,  sel: 1'b1, n: 4,  s: 30};
    tbl[2] = '{f: 4'd5,  l: 4'd5,  sel: 1'b1, n: 1,  s: 5};
    tbl[3] = '{f: 4'd0,  l: 4'd15, sel: 1'b0, n: 16, s: 120};

    rst = 1'b1; start1 = 1'b0; start0 = 1'b0; first_code = '0; last_code = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst ctrl", ctrl1, 0);
    check("rst busy", busy1, 0);
    check("rst smp_valid", sv1, 0);
    check("rst smp_code", sc1, 0);
    check("rst smp_data", sd1, 0);
    check("rst sum", sum1, 0);
    check("rst done", done1, 0);
    check("rst lat0 ctrl", ctrl0, 0);
    check("rst lat0 sum", sum0, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_sweep(tbl[i].sel, tbl[i].f, tbl[i].l, 1'b0, tbl[i].n, tbl[i].s,
                $sformatf("vec%0d", i));
    end

    // Reset mid-sweep after the third sample
    mon_sel = 1'b1;
    base  = q_code.size();
    dbase = done_cnt;
    first_code = 4'd0; last_code = 4'd9; start1 = 1'b1;
    @(negedge clk); #1;
    start1 = 1'b0;
    waited = 0;
    while (q_code.size() < base + 3 && waited < 100) begin
      @(negedge clk); #1;
      waited++;
    end
    check("abort three_samples", q_code.size() - base, 3);
    rst = 1'b1;
    @(negedge clk); #1;
    check("abort ctrl", ctrl1, 0);
    check("abort busy", busy1, 0);
    check("abort smp_valid", sv1, 0);
    check("abort smp_code", sc1, 0);
    check("abort smp_data", sd1, 0);
    check("abort sum", sum1, 0);
    check("abort done", done1, 0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    #1;
    check("abort no_done", done_cnt - dbase, 0);
    check("abort no_samples", q_code.size() - base, 3);
    run_sweep(1'b1, 4'd2, 4'd3, 1'b0, 2, 5, "after_abort");

    // start held high throughout a sweep, with bounds changing underneath
    run_sweep(1'b1, 4'd0, 4'd3, 1'b1, 4, 6, "start_spam");

    // Random sweeps against the model
    for (int k = 0; k < 8; k++) begin
      run_sweep(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), -1, -1,
                $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcase_sweep.md
TCASE_SWEEP -- requirements
Module: tcase_sweep

Interface
REQ-001 Parameter LAT, default 1: cycles from a ctrl change until the attached case decoder's out is valid; range 0..15.
REQ-002 Parameter W, default 4: width of ctrl codes and decoder out.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-006 first_code  in  W  first ctrl code of the sweep; latched on accepted start.
REQ-007 last_code  in  W  last ctrl code of the sweep; latched on accepted start.
REQ-008 ctrl  out  W  code driven to the case decoder's ctrl input.
REQ-009 dec_out  in  W  case decoder's out, returned to this block.
REQ-010 busy  out  1  high from the cycle after an accepted start until done.
REQ-011 smp_valid  out  1  one-cycle pulse per captured step.
REQ-012 smp_code  out  W  ctrl code belonging to the current sample.
REQ-013 smp_data  out  W  dec_out captured for that code.
REQ-014 sum  out  W+4  running unsigned sum of all captured dec_out values.
REQ-015 done  out  1  one-cycle pulse when the sweep completes.

Function
REQ-016 FSM states: IDLE, HOLD, DONE; IDLE->HOLD on start; HOLD->HOLD on each non-final step; HOLD->DONE after the final sample; DONE->IDLE unconditionally after one cycle.
REQ-017 Accepted start latches first_code/last_code, clears sum, and drives ctrl=first_code and busy=1 from the next edge.
REQ-018 Each code is held on ctrl for exactly LAT+1 cycles; at the final edge of the hold, dec_out is captured.
REQ-019 Capture edge: smp_valid=1, smp_code=held code, smp_data=dec_out, sum+=dec_out, and ctrl advances to code+1 mod 2^W (unless final) -- all registered on that same edge.
REQ-020 Codes step ascending modulo 2^W, wrapping 15->0 for W=4; step count = ((last_code-first_code) mod 2^W)+1.
REQ-021 first_code==last_code: exactly one step.
REQ-022 Sum is zero-extended, width W+4; no overflow possible for 2^W steps.
REQ-023 DONE cycle: done=1, busy=0, ctrl holds last_code, sum holds final value until next accepted start.
REQ-024 start while busy or in DONE is ignored; no restart, no effect on latched codes.
REQ-025 smp_valid and done never assert in the same cycle; done follows the final smp_valid by one cycle.
REQ-026 smp_code/smp_data hold their last values when smp_valid=0.

Reset
REQ-027 rst=1 at a clock edge forces: state=IDLE, ctrl=0, busy=0, smp_valid=0, smp_code=0, smp_data=0, sum=0, done=0, hold counter=0.
REQ-028 rst takes priority over start and over any in-progress sweep; a sweep aborted by rst produces no done pulse.
REQ-029 First start after rst deasserts is accepted normally on the next edge.

Structure
REQ-030 Shared package tcase_pkg holds the code width constant, the FSM state enum and the sum width (W+4).
REQ-031 One sub-module, tcase_hold_cnt: load-and-countdown hold counter with terminal-count output; FSM and datapath stay in tcase_sweep.

Verification
REQ-032 Bench stub decoder: registered identity (out<=ctrl), LAT=1.
REQ-033 first=0, last=9, start -> 10 smp_valid pulses, codes 0..9, 2 cycles apart, sum=45, done 1 cycle after the 10th sample.
REQ-034 first=14, last=1 -> codes 14,15,0,1 in order, sum=30, done once.
REQ-035 first=5, last=5 -> single sample code 5 data 5, sum=5, then done.
REQ-036 rst asserted after 3rd sample of 0..9 sweep -> all outputs 0 next cycle, no done; new sweep 2..3 gives sum=5.
REQ-037 start pulsed every cycle during a 0..3 sweep -> exactly 4 samples, one done, latched codes unchanged.
REQ-038 LAT=0 with combinational identity stub, 0..15 -> 16 samples on consecutive cycles, sum=120.
